// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, machine word and arbiter FSM states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_bus_arbiter_rr_pick.sv
// Round-robin picker: first set bit of mask at or after start, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] start,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    logic [SW-1:0] s;
    logic [IW-1:0] j;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        s     = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, start} + SW'(k);
            if (s >= SW'(N)) begin
                s = s - SW'(N);
            end
            j = s[IW-1:0];
            if (mask[j]) begin
                idx   = j;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Serialises cache requesters onto the single RAM port.
// Tiers: aged, then dcache (odd), then icache (even); round-robin within a tier.
module ram_bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_store,
    output logic [NREQ-1:0]          req_wait,
    output logic [DATA_W-1:0]        req_load,
    input  ramstate_t                ramstate,
    input  logic [DATA_W-1:0]        ramload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int IW    = $clog2(NREQ);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [AGE_W-1:0]  age_q [NREQ];
    logic [AGE_W-1:0]  age_d [NREQ];

    logic [NREQ-1:0]   req;
    logic [ADDR_W-1:0] addr_a  [NREQ];
    logic [DATA_W-1:0] store_a [NREQ];
    logic [NREQ-1:0]   aged_mask, dc_mask, ic_mask;
    logic [IW-1:0]     start;
    logic [IW-1:0]     aged_idx, dc_idx, ic_idx;
    logic              aged_v, dc_v, ic_v;
    logic              in_grant, g_live, done;

    assign req = req_ren | req_wen;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign store_a[gi] = req_store[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        aged_mask = '0;
        dc_mask   = '0;
        ic_mask   = '0;
        for (int i = 0; i < NREQ; i++) begin
            aged_mask[i] = req[i] && (age_q[i] == AGE_W'(MAX_WAIT));
            dc_mask[i]   = req[i] && (i % 2 == 1);
            ic_mask[i]   = req[i] && (i % 2 == 0);
        end
    end

    assign start = (last_q == IW'(NREQ - 1)) ? '0 : last_q + 1'b1;

    rr_pick #(.N(NREQ)) u_pick_aged (
        .mask(aged_mask), .start(start), .idx(aged_idx), .valid(aged_v)
    );
    rr_pick #(.N(NREQ)) u_pick_dc (
        .mask(dc_mask), .start(start), .idx(dc_idx), .valid(dc_v)
    );
    rr_pick #(.N(NREQ)) u_pick_ic (
        .mask(ic_mask), .start(start), .idx(ic_idx), .valid(ic_v)
    );

    assign in_grant = (state_q == GRANT);
    assign g_live   = req[grant_q];
    // A reset cycle never reports a completion, even if RAM says ACCESS.
    assign done     = in_grant && g_live && (ramstate == ACCESS) && !RST;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    if (aged_v) begin
                        grant_d = aged_idx;
                    end else if (dc_v) begin
                        grant_d = dc_idx;
                    end else if (ic_v) begin
                        grant_d = ic_idx;
                    end
                end
            end
            GRANT: begin
                if (!g_live) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            age_d[i] = age_q[i];
            if (!req[i]) begin
                age_d[i] = '0;
            end else if (in_grant && grant_q == IW'(i)) begin
                if (ramstate == ACCESS) begin
                    age_d[i] = '0;
                end
            end else if (age_q[i] < AGE_W'(MAX_WAIT)) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        req_wait = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (in_grant) begin
            ramWEN   = req_wen[grant_q];
            ramREN   = req_ren[grant_q] && !req_wen[grant_q];
            ramaddr  = addr_a[grant_q];
            ramstore = store_a[grant_q];
            if (done) begin
                req_wait[grant_q] = 1'b0;
            end
        end
    end

    assign req_load = ramload;
    assign grant_id = grant_q;
    assign busy     = in_grant;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            for (int i = 0; i < NREQ; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule
